// File: rtl/sram_4kx32_ctrl.sv
// ---------------------------------------------------------------------------
// sram_4kx32_ctrl
//
// Request-side controller for the sram_4Kx32 two-port SRAM. It takes
// single-beat read/write requests on a valid/ready handshake, drives the
// SRAM read and write ports, and returns read data as a one-cycle pulse.
// The SRAM has no byte enables, so a partial-word write is done as an
// internal read-modify-write. During the merge cycle the controller does
// not accept new requests.
//
// Configuration macro:
//   SRAM_CTRL_OUTREG_EN - when defined, rsp_valid/rsp_rdata are registered
//                         and read latency becomes 2 cycles. When undefined,
//                         rsp_rdata comes combinationally from mem_rd and
//                         read latency is 1 cycle.
//
// Ports:
//   CLK        in   1   clock, rising edge
//   RST        in   1   asynchronous active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   request accepted when valid & ready at a rising edge
//   req_write  in   1   1 = write, 0 = read
//   req_addr   in   AW  word address
//   req_wdata  in   32  write data
//   req_be     in   4   byte enables, bit i covers bits [8i+7:8i]
//   rsp_valid  out  1   one-cycle pulse per read
//   rsp_rdata  out  32  read data, 0 when rsp_valid is 0
//   mem_raddr  out  AW  SRAM RADDR
//   mem_waddr  out  AW  SRAM WADDR
//   mem_wd     out  32  SRAM WD
//   mem_wen    out  1   SRAM WEN
//   mem_rd     in   32  SRAM RD, valid the cycle after RADDR is sampled
// ---------------------------------------------------------------------------
module sram_4kx32_ctrl #(
  parameter int AW = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic [3:0]    req_be,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wd,
  output logic          mem_wen,
  input  logic [31:0]   mem_rd
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RMW_WR  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] rmwAddr_q, rmwAddr_d;
  logic [31:0]   rmwData_q, rmwData_d;
  logic [3:0]    rmwBe_q, rmwBe_d;
  logic          accept;
  logic          wenRaw;
  logic [31:0]   mergedWord;
  logic          rspFire;

  // The merge cycle is the only one that cannot take a new request; reset
  // also holds ready low so nothing is accepted while RST is high.
  assign req_ready = ~RST & (state_q != RMW_WR);
  assign accept    = req_valid & req_ready;

  // Byte-wise merge of the latched write data over the word read back from
  // the SRAM in the cycle before.
  always_comb begin
    mergedWord = mem_rd;
    for (int b = 0; b < 4; b++) begin
      if (rmwBe_q[b]) begin
        mergedWord[8*b +: 8] = rmwData_q[8*b +: 8];
      end
    end
  end

  // Next-state and SRAM port decode. A read address is only driven from the
  // request when a read is issued; otherwise the last issued address is held
  // so the SRAM address bus does not toggle needlessly.
  always_comb begin
    state_d   = IDLE;
    raddr_d   = raddr_q;
    rmwAddr_d = rmwAddr_q;
    rmwData_d = rmwData_q;
    rmwBe_d   = rmwBe_q;
    wenRaw    = 1'b0;
    mem_waddr = rmwAddr_q;
    mem_wd    = mergedWord;

    case (state_q)
      IDLE, RD_WAIT: begin
        if (accept) begin
          if (!req_write) begin
            raddr_d = req_addr;
            state_d = RD_WAIT;
          end else if (req_be == 4'hF) begin
            wenRaw    = 1'b1;
            mem_waddr = req_addr;
            mem_wd    = req_wdata;
          end else if (req_be != 4'h0) begin
            raddr_d   = req_addr;
            rmwAddr_d = req_addr;
            rmwData_d = req_wdata;
            rmwBe_d   = req_be;
            state_d   = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        wenRaw    = 1'b1;
        mem_waddr = rmwAddr_q;
        mem_wd    = mergedWord;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset kills any write immediately, including an in-flight merge write,
  // so the SRAM word keeps its old value.
  assign mem_wen   = wenRaw & ~RST;
  assign mem_raddr = raddr_d;

  // State and latched request fields.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      raddr_q   <= '0;
      rmwAddr_q <= '0;
      rmwData_q <= '0;
      rmwBe_q   <= '0;
    end else begin
      state_q   <= state_d;
      raddr_q   <= raddr_d;
      rmwAddr_q <= rmwAddr_d;
      rmwData_q <= rmwData_d;
      rmwBe_q   <= rmwBe_d;
    end
  end

  // Data for a read is on mem_rd exactly while we sit in RD_WAIT.
  assign rspFire = (state_q == RD_WAIT);

`ifdef SRAM_CTRL_OUTREG_EN
  logic        rspValid_q;
  logic [31:0] rspData_q;

  // Registered response: one extra cycle of latency, same throughput.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
    end else begin
      rspValid_q <= rspFire;
      rspData_q  <= rspFire ? mem_rd : 32'h0;
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspData_q;
`else
  assign rsp_valid = rspFire;
  assign rsp_rdata = rspFire ? mem_rd : 32'h0;
`endif

endmodule

// File: doc/sram_4kx32_ctrl.md
# sram_4kx32_ctrl

Request-side controller for the `sram_4Kx32` two-port SRAM.
- Accepts single-beat read/write requests on a valid/ready interface.
- Drives the SRAM's `RADDR`/`WADDR`/`WD`/`WEN` ports and returns read data.
- The SRAM has no byte enables, so partial-word writes are done as an internal read-modify-write (RMW).
- Sits between the core's data-memory bus adapter and the SRAM instance.

## Interface
Parameters:
- AW, 12, word address width; must match the SRAM depth. Data width is fixed at 32.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  one-cycle pulse per read; writes produce no response.
- rsp_rdata  out  32  read data; 0 whenever rsp_valid = 0.
- mem_raddr  out  AW  to SRAM `RADDR`.
- mem_waddr  out  AW  to SRAM `WADDR`.
- mem_wd  out  32  to SRAM `WD`.
- mem_wen  out  1  to SRAM `WEN`.
- mem_rd  in  32  from SRAM `RD`; valid the cycle after `RADDR` is sampled.

## Operation
States:
- IDLE
- RD_WAIT: read issued, data returns this cycle.
- RMW_WR: merge and write back.

Request classes:
- Read, accepted in cycle N:
  - mem_raddr = req_addr in cycle N.
  - Next state RD_WAIT.
  - In cycle N+1: rsp_valid = 1, rsp_rdata = mem_rd.
- Full write (req_be = 4'hF):
  - mem_wen = 1, mem_waddr = req_addr, mem_wd = req_wdata in the acceptance cycle.
  - Stays in or returns to IDLE. Single cycle.
- Partial write (req_be not 0 and not F):
  - At acceptance, issue a read of req_addr and latch addr/wdata/be.
  - Next state RMW_WR.
  - In RMW_WR: mem_wd = per-byte select (be ? wdata : mem_rd), mem_wen = 1, mem_waddr = latched addr.
  - Then return to IDLE.
- Null write (req_be = 0): accepted, mem_wen stays 0, no state change.

req_ready:
- 1 in IDLE and RD_WAIT, so reads and full writes sustain one per cycle.
- 0 in RMW_WR.

Transitions:
- RD_WAIT accepts a new request exactly as IDLE does.
- If nothing is accepted in RD_WAIT, go to IDLE.
- RMW_WR always goes to IDLE.

Collisions:
- A read and a write to the same address never occur in the same cycle: writes happen only at acceptance of a write or in RMW_WR, where no read is issued.
- Read-after-write to the same address returns the new data, because the SRAM updates at the write edge.

mem_raddr when no read is issued: holds its last value, which avoids needless toggling.

## Timing
- Read latency: acceptance to rsp_valid = 1 cycle; 2 cycles with the configuration macro.
- Full-write occupancy: 1 cycle. Partial-write occupancy: 2 cycles, with req_ready low in the 2nd.
- Back-to-back partial writes to the same address: the second RMW read (cycle N+2) observes the first write (edge ending N+1).
- No response backpressure. The consumer must accept every rsp_valid pulse.

Reset (RST high, asynchronous):
- State goes to IDLE.
- req_ready = 0 while RST is high, and 1 from the first cycle after release.
- mem_wen = 0, rsp_valid = 0, rsp_rdata = 0.
- Latched RMW fields and mem_raddr are cleared to 0.
- Reset in RD_WAIT drops the pending response.
- Reset in RMW_WR aborts the write (mem_wen forced 0 immediately); the SRAM word is unchanged.

## Configuration
- SRAM_CTRL_OUTREG_EN defined:
  - rsp_valid and rsp_rdata are registered. Read latency is 2 cycles (rsp at N+2).
  - Both registers reset to 0.
  - Throughput is unchanged.
  - The RMW merge still uses mem_rd directly.
- Not defined:
  - rsp_rdata = rsp_valid ? mem_rd : 0, combinational from mem_rd. Read latency is 1 cycle.

## Test plan
- Reset release: RST held 3 cycles, then low.
  - During reset: req_ready = 0, mem_wen = 0, rsp_valid = 0.
  - Cycle after release: req_ready = 1.
- Full write then read:
  - Write addr 0x010, data 0xDEADBEEF, be F → mem_wen = 1 for one cycle.
  - Read 0x010 in the next cycle → rsp_valid one cycle later with rsp_rdata = 0xDEADBEEF.
- Partial write RMW:
  - Preload 0x020 = 0x11223344.
  - Write data 0xAABBCCDD, be 4'b0101 → req_ready low for 1 cycle; mem_wd = 0x11BB33DD.
  - Subsequent read returns 0x11BB33DD.
- Streaming reads:
  - Reads to 0x000..0x007 on consecutive cycles → 8 consecutive rsp_valid pulses, in order, with correct data.
  - req_ready stays 1 throughout.
- Boundaries:
  - Write with be 0 to 0xFFF → mem_wen never asserts.
  - Full write and read at 0xFFF → correct data; no address wrap issues.
- Reset mid-RMW:
  - Assert RST in the RMW_WR cycle of a write to 0x030, preloaded 0x55555555 → mem_wen = 0 immediately.
  - After reset, a read of 0x030 returns 0x55555555.
